// File: rtl/udp_rx_scheduler.sv
// udp_rx_scheduler: shares a single UDP decoder between two FWFT receive
// channels. It grants channels round-robin, streams the granted datagram's
// words into the decoder, waits for fin (or a timeout), reports a per-packet
// status and pulses the decoder reset before the next grant.
module udp_rx_scheduler #(
  parameter int TIMEOUT = 1024,
  parameter int MAX_LEN = 1472
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req,
  input  logic [31:0] req0_dest_ip,
  input  logic [31:0] req0_src_ip,
  input  logic [15:0] req0_len_udp,
  input  logic [31:0] req0_data,
  input  logic [31:0] req1_dest_ip,
  input  logic [31:0] req1_src_ip,
  input  logic [15:0] req1_len_udp,
  input  logic [31:0] req1_data,
  output logic [1:0]  rd_en,
  output logic [1:0]  done,
  output logic [1:0]  status,
  output logic        grant_id,
  output logic        busy,
  output logic [31:0] dec_dest_ip,
  output logic [31:0] dec_src_ip,
  output logic [15:0] dec_len_udp,
  output logic [31:0] dec_data,
  output logic        dec_start,
  output logic        dec_reset,
  input  logic        dec_fin,
  input  logic        dec_ok
);

  localparam int TW = $clog2(TIMEOUT) + 1;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_STREAM   = 3'd1;
  localparam logic [2:0] S_WAIT_FIN = 3'd2;
  localparam logic [2:0] S_DROP     = 3'd3;
  localparam logic [2:0] S_REPORT   = 3'd4;
  localparam logic [2:0] S_CLEAR    = 3'd5;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_BAD_SUM = 2'b01;
  localparam logic [1:0] ST_LEN_ERR = 2'b10;
  localparam logic [1:0] ST_TIMEOUT = 2'b11;

  logic [2:0]    state;
  logic          last_grant;
  logic [16:0]   words_left;
  logic [TW-1:0] tcnt;
  logic          first_word;
  logic          dropped;

  logic          sel;
  logic [15:0]   sel_len;
  logic [16:0]   sel_words;
  logic          sel_bad;

  // Arbitration and length qualification for the channel that would win now.
  always_comb begin
    sel       = (req == 2'b11) ? ~last_grant : req[1];
    sel_len   = sel ? req1_len_udp : req0_len_udp;
    sel_words = ({1'b0, sel_len} + 17'd3) >> 2;
    sel_bad   = (sel_len < 16'd8) || (sel_len > 16'(MAX_LEN));
  end

  // Main sequencer: grant, stream or drop, wait for fin, report, clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      last_grant  <= 1'b1;
      grant_id    <= 1'b0;
      words_left  <= '0;
      tcnt        <= '0;
      first_word  <= 1'b0;
      dropped     <= 1'b0;
      status      <= ST_OK;
      dec_dest_ip <= '0;
      dec_src_ip  <= '0;
      dec_len_udp <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req != 2'b00) begin
            grant_id    <= sel;
            dec_dest_ip <= sel ? req1_dest_ip : req0_dest_ip;
            dec_src_ip  <= sel ? req1_src_ip : req0_src_ip;
            dec_len_udp <= sel_len;
            words_left  <= sel_words;
            first_word  <= 1'b1;
            dropped     <= sel_bad;
            if (!sel_bad) begin
              state <= S_STREAM;
            end else if (sel_words == 17'd0) begin
              status <= ST_LEN_ERR;
              state  <= S_REPORT;
            end else begin
              state <= S_DROP;
            end
          end
        end
        S_STREAM: begin
          first_word <= 1'b0;
          words_left <= words_left - 17'd1;
          if (words_left == 17'd1) begin
            tcnt  <= '0;
            state <= S_WAIT_FIN;
          end
        end
        S_WAIT_FIN: begin
          if (dec_fin) begin
            status <= dec_ok ? ST_OK : ST_BAD_SUM;
            state  <= S_REPORT;
          end else if (tcnt == TW'(TIMEOUT - 1)) begin
            status <= ST_TIMEOUT;
            state  <= S_REPORT;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        S_DROP: begin
          words_left <= words_left - 17'd1;
          if (words_left == 17'd1) begin
            status <= ST_LEN_ERR;
            state  <= S_REPORT;
          end
        end
        S_REPORT: begin
          last_grant <= grant_id;
          state      <= S_CLEAR;
        end
        S_CLEAR: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Decoder and channel strobes decoded from the current state.
  always_comb begin
    rd_en     = 2'b00;
    done      = 2'b00;
    dec_data  = '0;
    dec_start = 1'b0;
    dec_reset = 1'b1;
    busy      = (state != S_IDLE);
    case (state)
      S_STREAM: begin
        rd_en[grant_id] = 1'b1;
        dec_data        = grant_id ? req1_data : req0_data;
        dec_start       = first_word;
        dec_reset       = 1'b0;
      end
      S_WAIT_FIN: begin
        dec_reset = 1'b0;
      end
      S_DROP: begin
        rd_en[grant_id] = 1'b1;
      end
      S_REPORT: begin
        done[grant_id] = 1'b1;
        dec_reset      = dropped;
      end
      default: begin
        dec_reset = 1'b1;
      end
    endcase
  end

endmodule
